// File: rtl/alu_pkg.sv
// Shared types and helpers for the sequential ALU and its combinational datapath.
package alu_pkg;

    typedef enum logic [2:0] {
        OpPass = 3'b000,
        OpLsl  = 3'b001,
        OpAdd  = 3'b010,
        OpSub  = 3'b011,
        OpAnd  = 3'b100,
        OpOr   = 3'b101,
        OpXor  = 3'b110,
        OpMul  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DONE     = 2'd2
    } alu_state_e;

    // {V,C} from the operand MSBs and the top two bits of the WIDTH+1-bit sum;
    // the carry into the MSB is recovered as a ^ b ^ sum at that bit.
    function automatic logic [1:0] add_vc(input logic       a_msb,
                                          input logic       b_msb,
                                          input logic [1:0] sum_top);
        logic carry_in_msb;
        carry_in_msb = a_msb ^ b_msb ^ sum_top[0];
        return {carry_in_msb ^ sum_top[1], sum_top[1]};
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle datapath for every op except MUL, with N/Z/V/C flags.
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  alu_op_e          i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_n,
    output logic             o_z,
    output logic             o_v,
    output logic             o_c
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic             w_is_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic [1:0]       w_vc;

    // Subtract shares the adder: A + ~B + 1.
    assign w_is_sub = (i_op == OpSub);
    assign w_b_eff  = w_is_sub ? ~i_b : i_b;
    assign w_sum    = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};
    assign w_vc     = add_vc(i_a[WIDTH-1], w_b_eff[WIDTH-1], w_sum[WIDTH:WIDTH-1]);

    always_comb begin
        o_result = '0;
        o_v      = 1'b0;
        o_c      = 1'b0;
        unique case (i_op)
            OpPass: o_result = i_b;
            OpLsl:  o_result = i_a << i_b[SHW-1:0];
            OpAdd, OpSub: begin
                o_result = w_sum[WIDTH-1:0];
                o_v      = w_vc[1];
                o_c      = w_vc[0];
            end
            OpAnd:  o_result = i_a & i_b;
            OpOr:   o_result = i_a | i_b;
            OpXor:  o_result = i_a ^ i_b;
            OpMul:  o_result = '0;
            default: o_result = '0;
        endcase
        o_n = o_result[WIDTH-1];
        o_z = (o_result == '0);
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops via alu_comb, MUL via WIDTH-step shift-and-add.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);
    localparam int unsigned     SHW       = $clog2(WIDTH);
    localparam logic [SHW:0]    LAST_STEP = (SHW + 1)'(WIDTH - 1);

    alu_state_e       r_state, w_state_next;
    logic [WIDTH-1:0] r_acc, r_mcand, r_mplier;
    logic [SHW:0]     r_count;
    logic [WIDTH-1:0] r_result;
    logic             r_n, r_z, r_v, r_c;

    alu_op_e          w_op;
    logic             w_accept, w_is_mul, w_last;
    logic [WIDTH-1:0] w_acc_step;
    logic [WIDTH-1:0] w_comb_result;
    logic             w_comb_n, w_comb_z, w_comb_v, w_comb_c;

    assign w_op       = alu_op_e'(cntrl);
    assign w_is_mul   = (w_op == OpMul);
    assign w_accept   = in_valid && (r_state == IDLE);
    assign w_last     = (r_count == LAST_STEP);
    assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .i_a      (A),
        .i_b      (B),
        .i_op     (w_op),
        .o_result (w_comb_result),
        .o_n      (w_comb_n),
        .o_z      (w_comb_z),
        .o_v      (w_comb_v),
        .o_c      (w_comb_c)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:     if (w_accept) w_state_next = w_is_mul ? MUL_BUSY : DONE;
            MUL_BUSY: if (w_last)   w_state_next = DONE;
            DONE:     if (out_ready) w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Multiply iteration: fixed WIDTH steps, no early exit on a zero multiplier.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else if (w_accept && w_is_mul) begin
            r_acc    <= '0;
            r_mcand  <= A;
            r_mplier <= B;
            r_count  <= '0;
        end else if (r_state == MUL_BUSY) begin
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_result <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_v      <= 1'b0;
            r_c      <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_result <= w_comb_result;
            r_n      <= w_comb_n;
            r_z      <= w_comb_z;
            r_v      <= w_comb_v;
            r_c      <= w_comb_c;
        end else if ((r_state == MUL_BUSY) && w_last) begin
            r_result <= w_acc_step;
            r_n      <= w_acc_step[WIDTH-1];
            r_z      <= (w_acc_step == '0);
            r_v      <= 1'b0;
            r_c      <= 1'b0;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign negative  = r_n;
    assign zero      = r_z;
    assign overflow  = r_v;
    assign carry_out = r_c;

endmodule
